// File: rtl/rng_health_monitor.sv
// rng_health_monitor: RCT/APT health tests on a 2-bit symbol stream, packing healthy symbols into bytes.
// Define RNG_HEALTH_APT_EN to build the adaptive proportion test.
module rng_health_monitor #(
    parameter int REP_LIMIT = 8,
    parameter int WINDOW    = 64,
    parameter int APT_LIMIT = 40
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_r,
    input  logic       i_clr_fail,
    input  logic       i_ready,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_drop,
    output logic       o_rep_fail,
    output logic       o_apt_fail,
    output logic       o_health_ok
);
    localparam int            CW       = $clog2(WINDOW);
    localparam logic [7:0]    REP_MAX  = 8'(REP_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

    logic          accept;
    logic          offer;
    logic [1:0]    prev_q, prev_d;
    logic          has_prev_q, has_prev_d;
    logic [7:0]    rep_cnt_q, rep_cnt_d;
    logic          rep_fail_q, rep_fail_d;
    logic          apt_fail_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic          warm_q, warm_d;
    logic [1:0]    slot_q, slot_d;
    logic [5:0]    sh_q, sh_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;
    logic          ok_q, ok_d;

    assign accept = i_en & ~i_clr_fail;

`ifdef RNG_HEALTH_APT_EN
    localparam logic [8:0] APT_MAX = 9'(APT_LIMIT);

    logic [1:0] ref_q, ref_d;
    logic [8:0] apt_cnt_q, apt_cnt_d;
    logic       apt_fail_q;

    always_comb begin
        ref_d      = ref_q;
        apt_cnt_d  = apt_cnt_q;
        apt_fail_d = apt_fail_q;
        if (i_clr_fail) begin
            ref_d      = 2'd0;
            apt_cnt_d  = 9'd0;
            apt_fail_d = 1'b0;
        end else if (i_en) begin
            if (win_cnt_q == '0) begin
                ref_d     = i_r;
                apt_cnt_d = 9'd1;
            end else if (i_r == ref_q && apt_cnt_q != APT_MAX) begin
                apt_cnt_d = apt_cnt_q + 9'd1;
                if (apt_cnt_d == APT_MAX) apt_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ref_q      <= 2'd0;
            apt_cnt_q  <= 9'd0;
            apt_fail_q <= 1'b0;
        end else begin
            ref_q      <= ref_d;
            apt_cnt_q  <= apt_cnt_d;
            apt_fail_q <= apt_fail_d;
        end
    end

    assign o_apt_fail = apt_fail_q;
`else
    assign apt_fail_d = 1'b0;
    assign o_apt_fail = 1'b0;
`endif

    always_comb begin
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        rep_cnt_d  = rep_cnt_q;
        rep_fail_d = rep_fail_q;
        win_cnt_d  = win_cnt_q;
        warm_d     = warm_q;
        slot_d     = slot_q;
        sh_d       = sh_q;
        if (i_clr_fail) begin
            has_prev_d = 1'b0;
            rep_cnt_d  = 8'd0;
            rep_fail_d = 1'b0;
            win_cnt_d  = '0;
            warm_d     = 1'b0;
            slot_d     = 2'd0;
        end else if (i_en) begin
            prev_d     = i_r;
            has_prev_d = 1'b1;
            if (!has_prev_q || i_r != prev_q) begin
                rep_cnt_d = 8'd1;
            end else if (rep_cnt_q != REP_MAX) begin
                rep_cnt_d = rep_cnt_q + 8'd1;
                if (rep_cnt_d == REP_MAX) rep_fail_d = 1'b1;
            end
            // WINDOW is a power of two, so the counter wraps on its own
            win_cnt_d = win_cnt_q + 1'b1;
            if (win_cnt_q == CNT_LAST) warm_d = 1'b1;
            slot_d = slot_q + 2'd1;
            case (slot_q)
                2'd0:    sh_d[1:0] = i_r;
                2'd1:    sh_d[3:2] = i_r;
                2'd2:    sh_d[5:4] = i_r;
                default: sh_d      = sh_q;
            endcase
        end
    end

    // Fail closed: a byte finished by the failing symbol is never offered
    assign offer = accept && slot_q == 2'd3 && warm_q && !rep_fail_d && !apt_fail_d;

    always_comb begin
        byte_d  = byte_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        if (offer && (!valid_q || i_ready)) begin
            byte_d  = {i_r, sh_q};
            valid_d = 1'b1;
        end else if (offer) begin
            drop_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    assign ok_d = warm_d & ~rep_fail_d & ~apt_fail_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q     <= 2'd0;
            has_prev_q <= 1'b0;
            rep_cnt_q  <= 8'd0;
            rep_fail_q <= 1'b0;
            win_cnt_q  <= '0;
            warm_q     <= 1'b0;
            slot_q     <= 2'd0;
            sh_q       <= 6'd0;
            byte_q     <= 8'd0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_fail_q <= rep_fail_d;
            win_cnt_q  <= win_cnt_d;
            warm_q     <= warm_d;
            slot_q     <= slot_d;
            sh_q       <= sh_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            ok_q       <= ok_d;
        end
    end

    assign o_byte      = byte_q;
    assign o_valid     = valid_q;
    assign o_drop      = drop_q;
    assign o_rep_fail  = rep_fail_q;
    assign o_health_ok = ok_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// tb_rng_health_monitor: directed and randomized checks of rng_health_monitor
// against a history-based reference model.
module tb_rng_health_monitor;
    localparam int REP_LIMIT = 8;
    localparam int WINDOW    = 64;
    localparam int APT_LIMIT = 40;
`ifdef RNG_HEALTH_APT_EN
    localparam bit APT_ON = 1'b1;
`else
    localparam bit APT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] r = 2'd0;
    logic       clr = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] o_byte;
    logic       o_valid, o_drop, o_rep_fail, o_apt_fail, o_health_ok;

    always #5 clk = ~clk;

    rng_health_monitor #(
        .REP_LIMIT(REP_LIMIT),
        .WINDOW   (WINDOW),
        .APT_LIMIT(APT_LIMIT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_en       (en),
        .i_r        (r),
        .i_clr_fail (clr),
        .i_ready    (rdy),
        .o_byte     (o_byte),
        .o_valid    (o_valid),
        .o_drop     (o_drop),
        .o_rep_fail (o_rep_fail),
        .o_apt_fail (o_apt_fail),
        .o_health_ok(o_health_ok)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: keeps every symbol accepted since the last clear/reset
    logic [1:0] hist[$];
    bit         m_rf, m_af, m_v, m_d, m_ok, live;
    logic [7:0] m_b;

    always @(posedge clk) begin : model
        bit         offer, warm_before;
        int         n, run, s, cnt;
        logic [7:0] nb;
        offer = 1'b0;
        nb    = 8'd0;
        if (rst) begin
            hist.delete();
            m_rf = 0; m_af = 0; m_v = 0; m_d = 0; m_ok = 0;
            m_b  = 8'd0;
            live = 1'b1;
        end else begin
            m_d = 1'b0;
            if (clr) begin
                hist.delete();
                m_rf = 0;
                m_af = 0;
            end else if (en) begin
                warm_before = hist.size() >= WINDOW;
                hist.push_back(r);
                n   = hist.size();
                run = 0;
                for (int i = n - 1; i >= 0 && run < REP_LIMIT; i--) begin
                    if (hist[i] != hist[n-1]) break;
                    run++;
                end
                if (run >= REP_LIMIT) m_rf = 1'b1;
                if (APT_ON) begin
                    s   = ((n - 1) / WINDOW) * WINDOW;
                    cnt = 0;
                    for (int i = s; i < n; i++)
                        if (hist[i] == hist[s]) cnt++;
                    if (cnt >= APT_LIMIT) m_af = 1'b1;
                end
                if (n % 4 == 0 && warm_before && !m_rf && !m_af) begin
                    offer = 1'b1;
                    nb    = {hist[n-1], hist[n-2], hist[n-3], hist[n-4]};
                end
            end
            if (offer && (!m_v || rdy)) begin
                m_b = nb;
                m_v = 1'b1;
            end else if (offer) begin
                m_d = 1'b1;
            end else if (m_v && rdy) begin
                m_v = 1'b0;
            end
            m_ok = hist.size() >= WINDOW && !m_rf && !m_af;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_byte", o_byte, m_b);
            chk("cyc_valid", o_valid, m_v);
            chk("cyc_drop", o_drop, m_d);
            chk("cyc_rep_fail", o_rep_fail, m_rf);
            chk("cyc_apt_fail", o_apt_fail, m_af);
            chk("cyc_health_ok", o_health_ok, m_ok);
        end
    end

    task automatic step(input logic e, input logic [1:0] s, input logic c, input logic rd);
        en  = e;
        r   = s;
        clr = c;
        rdy = rd;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] last = 2'd0;
    logic [1:0] apt_pat [8];

    initial begin
        apt_pat = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk("reset_valid", o_valid, 0);
        chk("reset_byte", o_byte, 0);
        chk("reset_ok", o_health_ok, 0);

        for (int i = 0; i < 64; i++) begin
            step(1, 2'(i % 4), 0, 0);
            if (i == 62) chk("warm_ok_at63", o_health_ok, 0);
        end
        chk("warm_ok_at64", o_health_ok, 1);
        chk("warm_no_valid", o_valid, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("valid_before68", o_valid, 0);
            step(1, 2'(i), 0, 0);
        end
        chk("first_valid", o_valid, 1);
        chk("first_byte", o_byte, 8'hE4);

        for (int i = 0; i < 8; i++) begin
            step(1, 2'(i % 4), 0, 0);
            if (i == 3) chk("bp_drop", o_drop, 1);
            if (i == 4) chk("bp_drop_pulse", o_drop, 0);
        end
        chk("bp_byte_held", o_byte, 8'hE4);

        step(1, 3, 0, 0);
        step(1, 2, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        chk("handoff_valid", o_valid, 1);
        chk("handoff_byte", o_byte, 8'h1B);
        chk("handoff_drop", o_drop, 0);
        step(0, 0, 0, 1);
        chk("consume_valid", o_valid, 0);

        for (int i = 0; i < 7; i++) step(1, 2, 0, 1);
        chk("rct_7_ok", o_rep_fail, 0);
        step(1, 2, 0, 1);
        chk("rct_8_fail", o_rep_fail, 1);
        chk("rct_8_ok", o_health_ok, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 2'(i % 4), 0, 1);
            chk("rct_no_valid", o_valid, 0);
        end

        step(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        chk("clr_rep", o_rep_fail, 0);
        chk("clr_apt", o_apt_fail, 0);
        chk("clr_ok", o_health_ok, 0);
        for (int i = 0; i < 64; i++) begin
            step(1, 2'(i % 4), 0, 1);
            if (i == 62) chk("clr_rewarm_63", o_health_ok, 0);
        end
        chk("clr_rewarm_64", o_health_ok, 1);

        step(0, 0, 1, 1);
        for (int i = 0; i < 64; i++) begin
            step(1, apt_pat[i%8], 0, 1);
            if (i == 61) chk("apt_39", o_apt_fail, 0);
            if (i == 62) chk("apt_40", o_apt_fail, 32'(APT_ON));
        end
        chk("apt_no_rct", o_rep_fail, 0);

        for (int k = 0; k < 3000; k++) begin
            logic       e, c, rd;
            logic [1:0] s;
            int         bias;
            bias = ((k / 600) % 3) * 22;
            e    = $urandom_range(0, 9) < 8;
            rd   = $urandom_range(0, 3) != 0;
            c    = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 99) < bias) s = 2'd3;
            else if ($urandom_range(0, 5) == 0) s = last;
            else s = 2'($urandom_range(0, 3));
            if (e) last = s;
            rst = (k == 1700);
            step(e, s, c, rd);
        end
        rst = 1'b0;
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
